fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the combinational, word-indexed instruction memory.
- Holds the byte-address PC and drives the word index to imem each cycle.
- Captures the returned instruction into a 2-entry prefetch buffer and delivers {pc, instr} to decode over a valid/ready handshake.
- Handles stall (backpressure), fetch enable and branch/jump redirect with buffer flush; sits between imem and the decode stage.

---
 rtl/fetch_ctrl.sv | 122 ++++++++++++
 tb/tb_fetch_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: walks the PC through a word-indexed imem and
// hands {pc, instr} to decode through a 2-entry prefetch buffer.
module fetch_ctrl #(
  parameter int          DWIDTH   = 32,
  parameter int          AWIDTH   = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  output logic [31:0]       imem_addr,
  input  logic [DWIDTH-1:0] imem_instr,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_instr,
  output logic [31:0]       out_pc,
  output logic              misalign
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STALL
  } state_t;

  state_t            state;
  logic [31:0]       pc;

  // The head entry lives directly in the out_* registers; slot_* is the second entry.
  logic              slot_valid;
  logic [31:0]       slot_pc;
  logic [DWIDTH-1:0] slot_instr;

  logic full;
  logic pop;
  logic push;

  assign full      = out_valid & slot_valid;
  assign pop       = out_valid & out_ready;
  assign push      = (state != IDLE) & fetch_en & ~redirect_valid & (~full | pop);
  assign imem_addr = {{(32 - AWIDTH){1'b0}}, pc[AWIDTH+1:2]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      out_valid  <= 1'b0;
      out_pc     <= 32'd0;
      out_instr  <= '0;
      slot_valid <= 1'b0;
      slot_pc    <= 32'd0;
      slot_instr <= '0;
      misalign   <= 1'b0;
    end else begin
      misalign <= redirect_valid & (redirect_pc[1:0] != 2'b00);

      if (redirect_valid) begin
        // Flush wins over any concurrent pop; the PC is always aligned down.
        pc         <= {redirect_pc[31:2], 2'b00};
        out_valid  <= 1'b0;
        slot_valid <= 1'b0;
        state      <= fetch_en ? RUN : IDLE;
      end else begin
        if (push) begin
          pc <= pc + 32'd4;
        end

        if (pop) begin
          if (slot_valid) begin
            out_pc    <= slot_pc;
            out_instr <= slot_instr;
            if (push) begin
              slot_pc    <= pc;
              slot_instr <= imem_instr;
            end else begin
              slot_valid <= 1'b0;
            end
          end else if (push) begin
            out_pc    <= pc;
            out_instr <= imem_instr;
          end else begin
            out_valid <= 1'b0;
          end
        end else if (push) begin
          if (out_valid) begin
            slot_pc    <= pc;
            slot_instr <= imem_instr;
            slot_valid <= 1'b1;
          end else begin
            out_pc    <= pc;
            out_instr <= imem_instr;
            out_valid <= 1'b1;
          end
        end

        case (state)
          IDLE: begin
            if (fetch_en) state <= RUN;
          end
          RUN: begin
            if (!fetch_en) begin
              state <= IDLE;
            end else if (!pop && (full || (out_valid && push))) begin
              state <= STALL;
            end
          end
          STALL: begin
            if (!fetch_en) begin
              state <= IDLE;
            end else if (pop) begin
              state <= RUN;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: stimulus queues the expected {pc, instr}
// deliveries, a negedge monitor pops and compares on every handshake.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t expQ[$];
  int     checkCount = 0;
  int     passCount  = 0;

  fetch_ctrl #(
    .DWIDTH  (32),
    .AWIDTH  (5),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_en      (fetch_en),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .misalign      (misalign)
  );

  always #5 clk = ~clk;

  // Memory image: word k holds 0x1000_0000 + k.
  assign imem_instr = 32'h1000_0000 + imem_addr;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic expectEntry(input logic [31:0] pc, input logic [31:0] word);
    entry_t e;
    e.pc    = pc;
    e.instr = 32'h1000_0000 + word;
    expQ.push_back(e);
  endtask

  // Advance one clock; inputs are driven and registered outputs read 1 time unit after the edge.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDrain(input string name);
    int budget;
    budget = 60;
    while (expQ.size() != 0 && budget > 0) begin
      applyStimulus(1);
      budget--;
    end
    checkOutput({name, "_drained"}, 32'(expQ.size()), 32'd0);
    expQ.delete();
    applyStimulus(3);
  endtask

  always @(negedge clk) begin
    entry_t e;
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_output_pc", out_pc, 32'hFFFF_FFFF);
      end else begin
        e = expQ.pop_front();
        checkOutput("out_pc", out_pc, e.pc);
        checkOutput("out_instr", out_instr, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset          = 1'b1;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    out_ready      = 1'b0;

    // Reset values, then a free-running stream of 8 instructions.
    applyStimulus(2);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_pc", out_pc, 32'd0);
    checkOutput("rst_out_instr", out_instr, 32'd0);
    checkOutput("rst_misalign", 32'(misalign), 32'd0);
    checkOutput("rst_imem_addr", imem_addr, 32'd0);
    for (int k = 0; k < 8; k++) expectEntry(32'(4 * k), 32'(k));
    reset     = 1'b0;
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1);
    checkOutput("stream_valid_1cyc", 32'(out_valid), 32'd0);
    applyStimulus(1);
    checkOutput("stream_valid_2cyc", 32'(out_valid), 32'd1);
    applyStimulus(7);
    fetch_en = 1'b0;
    waitDrain("stream");

    // Backpressure: buffer saturates at two entries and pc stops at 8.
    reset     = 1'b1;
    out_ready = 1'b0;
    fetch_en  = 1'b1;
    applyStimulus(1);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) expectEntry(32'(4 * k), 32'(k));
    applyStimulus(2);
    checkOutput("bp_first_valid", 32'(out_valid), 32'd1);
    applyStimulus(5);
    checkOutput("bp_imem_addr", imem_addr, 32'd2);
    checkOutput("bp_head_pc", out_pc, 32'd0);
    checkOutput("bp_head_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    applyStimulus(1);
    fetch_en = 1'b0;
    waitDrain("backpressure");

    // Redirect to 0x40 while the buffer holds pc 12 and 16.
    out_ready = 1'b0;
    fetch_en  = 1'b1;
    applyStimulus(3);
    checkOutput("redir_full_valid", 32'(out_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    expectEntry(32'h40, 32'd16);
    expectEntry(32'h44, 32'd17);
    applyStimulus(1);
    checkOutput("redir_flush_valid", 32'(out_valid), 32'd0);
    checkOutput("redir_imem_addr", imem_addr, 32'd16);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    applyStimulus(1);
    checkOutput("redir_target_valid", 32'(out_valid), 32'd1);
    applyStimulus(1);
    fetch_en = 1'b0;
    waitDrain("redirect");

    // Misaligned redirect while idle: 0x46 aligns down to 0x44.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0046;
    applyStimulus(1);
    checkOutput("mis_pulse", 32'(misalign), 32'd1);
    checkOutput("mis_idle_valid", 32'(out_valid), 32'd0);
    redirect_valid = 1'b0;
    fetch_en       = 1'b1;
    expectEntry(32'h44, 32'd17);
    expectEntry(32'h48, 32'd18);
    applyStimulus(1);
    checkOutput("mis_pulse_end", 32'(misalign), 32'd0);
    applyStimulus(2);
    fetch_en = 1'b0;
    waitDrain("misalign");

    // Word index wraps from 31 back to 0 at pc 0x80.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_007C;
    applyStimulus(1);
    checkOutput("wrap_imem_addr_31", imem_addr, 32'd31);
    checkOutput("wrap_no_misalign", 32'(misalign), 32'd0);
    redirect_valid = 1'b0;
    fetch_en       = 1'b1;
    expectEntry(32'h7C, 32'd31);
    expectEntry(32'h80, 32'd0);
    applyStimulus(2);
    checkOutput("wrap_imem_addr_0", imem_addr, 32'd0);
    applyStimulus(1);
    fetch_en = 1'b0;
    waitDrain("wrap");

    // Reset with two entries buffered and decode stalled.
    out_ready = 1'b0;
    fetch_en  = 1'b1;
    applyStimulus(3);
    checkOutput("rst2_pre_valid", 32'(out_valid), 32'd1);
    checkOutput("rst2_pre_pc", out_pc, 32'h84);
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("rst2_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst2_out_pc", out_pc, 32'd0);
    checkOutput("rst2_out_instr", out_instr, 32'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    expectEntry(32'h0, 32'd0);
    expectEntry(32'h4, 32'd1);
    applyStimulus(2);
    checkOutput("rst2_imem_addr", imem_addr, 32'd1);
    applyStimulus(1);
    fetch_en = 1'b0;
    waitDrain("restart");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
